// File: rtl/tff_pkg.sv
// Shared encodings for the T-flip-flop up/down counter.
// Latency: n/a (constants only).
// Backpressure: n/a.
package tff_pkg;

  // Direction encoding carried on the 'up' input.
  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  // Boundary behaviour selected by the SATURATE parameter.
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

endpackage : tff_pkg

// File: rtl/tff_cell.sv
// Single T flip-flop: the stored bit inverts on each rising edge with t=1.
// Latency: one clock from t to q.
// Backpressure: none; t=0 holds the bit.
//
// Ports:
//   clk  - clock, rising-edge active
//   rst  - synchronous active-high reset, forces q=0
//   t    - toggle request
//   q    - stored bit
//   qbar - complement of q
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q,
  output logic qbar
);

  logic q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_q ^ t;
    end
  end

  assign q    = q_q;
  assign qbar = ~q_q;

endmodule : tff_cell

// File: rtl/tff_updown_counter.sv
// Modulo-MODULUS up/down counter built from per-bit T cells, with load, wrap/saturate.
// Latency: one clock from en/load to q; tc is combinational; wrap lags the wrapping step by one edge.
// Backpressure: none; en=0 and load=0 freezes the count.
//
// Ports:
//   clk  - clock, rising-edge active
//   rst  - synchronous active-high reset (q=0, wrap=0)
//   en   - count enable
//   up   - direction, UP=1 increments, DOWN=0 decrements
//   load - parallel load strobe (clamps d to MODULUS-1), beats en
//   d    - parallel load value
//   q    - registered count
//   qbar - ~q
//   tc   - terminal count for the current direction
//   wrap - one-cycle pulse in the cycle after a wrapping step
module tff_updown_counter
  import tff_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

  logic [WIDTH-1:0] next_d;
  logic [WIDTH-1:0] t;
  logic             at_max;
  logic             at_zero;
  logic             wrap_d;
  logic             wrap_q;
  logic [31:0]      d_ext;

  // Next-state, clamp, boundary detection and toggle vector in one place.
  always_comb begin
    next_d  = q;
    wrap_d  = 1'b0;
    d_ext   = 32'(d);
    at_max  = (q == MAX_Q);
    at_zero = (q == '0);
    tc      = ((up == UP) & at_max) | ((up == DOWN) & at_zero);

    if (load) begin
      next_d = (d_ext < 32'(MODULUS)) ? d : MAX_Q;
    end else if (en) begin
      if (up == UP) begin
        if (at_max) begin
          if (SATURATE == MODE_SAT) begin
            next_d = MAX_Q;
          end else begin
            next_d = '0;
            wrap_d = 1'b1;
          end
        end else begin
          next_d = q + ONE_Q;
        end
      end else begin
        if (at_zero) begin
          if (SATURATE == MODE_SAT) begin
            next_d = '0;
          end else begin
            next_d = MAX_Q;
            wrap_d = 1'b1;
          end
        end else begin
          next_d = q - ONE_Q;
        end
      end
    end

    // Each cell only needs to know which bits differ from the target.
    t = q ^ next_d;
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    tff_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .t    (t[gi]),
      .q    (q[gi]),
      .qbar (qbar[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;

endmodule : tff_updown_counter

// File: doc/tff_updown_counter.md
TFF_UPDOWN_COUNTER -- requirements
Module: tff_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter bit width (legal range 2..16).
REQ-002 SHALL have parameter MODULUS, default 16, count sequence length (legal range 2..2**WIDTH); count range is 0..MODULUS-1.
REQ-003 SHALL have parameter SATURATE, default 0: 0 = wrap at the boundaries, 1 = hold at the boundaries.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  input  1  count enable.
REQ-007 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 SHALL have port load  input  1  synchronous parallel load strobe.
REQ-009 SHALL have port d  input  WIDTH  parallel load value.
REQ-010 SHALL have port q  output  WIDTH  registered count value.
REQ-011 SHALL have port qbar  output  WIDTH  bitwise complement of q, always ~q.
REQ-012 SHALL have port tc  output  1  combinational terminal count: (up & q==MODULUS-1) | (~up & q==0).
REQ-013 SHALL have port wrap  output  1  registered one-cycle pulse, asserted in the cycle after a wrapping update.

Function
REQ-014 SHALL apply per-edge priority rst > load > en > hold.
REQ-015 SHALL, on load, set q to d if d < MODULUS, else to MODULUS-1 (clamp); load ignores en and up and clears wrap.
REQ-016 SHALL, with en=1 and load=0, step q by +1 (up=1) or -1 (up=0) with one-cycle latency.
REQ-017 SHALL, with SATURATE=0, step MODULUS-1 to 0 when counting up and 0 to MODULUS-1 when counting down, and set wrap=1 for exactly the following cycle.
REQ-018 SHALL, with SATURATE=1, hold q at MODULUS-1 when counting up and at 0 when counting down; wrap is never asserted.
REQ-019 SHALL, with en=0 and load=0, hold q and drive wrap=0.
REQ-020 SHALL update every q bit through a T-cell whose toggle input is t[i] = q[i] ^ next[i]; no bit is written directly except by reset.
REQ-021 SHALL allow up to change on any cycle; the step direction is taken from up as sampled at the same edge.
REQ-022 SHALL keep qbar equal to ~q in every cycle, including reset and load cycles; q and qbar are never X after the first reset edge.
REQ-023 SHALL keep q within 0..MODULUS-1 at all times after reset.

Reset
REQ-024 SHALL, on a rising clk edge with rst=1, set q=0, qbar=all ones and wrap=0, regardless of load and en.
REQ-025 SHALL, when rst is asserted mid-count, abandon any pending wrap pulse, and SHALL resume counting from 0 on the first edge with rst=0.
REQ-026 SHALL leave the state undefined before the first reset edge; no initial blocks are used.

Structure
REQ-027 SHALL place the direction encodings (UP=1, DOWN=0) and the mode constants (MODE_WRAP=0, MODE_SAT=1) in a shared package, tff_pkg.
REQ-028 SHALL instantiate WIDTH copies of a sub-module tff_cell (ports clk, rst, t, q, qbar; synchronous active-high reset to q=0), generated per bit.
REQ-029 SHALL compute next, the clamp, the boundary detection and t[] in one combinational block in the top-level module; wrap is a single flop in the top-level module.

Verification (WIDTH=4, MODULUS=10, SATURATE=0 unless stated)
REQ-030 SHALL cover: rst=1 for 2 cycles -> q=0, qbar=4'hF, wrap=0; then en=1, up=1 for 12 cycles -> q=1..9,0,1,2, with wrap=1 only in the cycle where q=0.
REQ-031 SHALL cover: load=1, d=3, then en=1, up=0 for 5 cycles -> q=3,2,1,0,9,8; tc=1 while q=0; wrap pulses once, with q=9.
REQ-032 SHALL cover: load=1, d=12 -> q=9 (clamped); load=1 together with en=1 in the same cycle -> the load value wins, q=d.
REQ-033 SHALL cover, with SATURATE=1: count up from 8 for 4 cycles -> q=9,9,9,9 with wrap=0; then count down from 1 for 3 cycles -> q=0,0,0.
REQ-034 SHALL cover: rst=1 asserted in the same cycle as a wrapping increment at q=9 -> q=0 and wrap=0 on the next cycle.
REQ-035 SHALL cover: random en/up/load stimulus for 1000 cycles -> q matches a reference model every cycle, qbar==~q every cycle, and q<10 every cycle.
